// File: rtl/decoder_4_to_16.sv
// Registered 4-to-16 decoder: sel is sampled on clk and exactly one line is driven
// active while en is high. ACTIVE_LOW selects one-hot or one-cold outputs.
module decoder_4_to_16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sel,
    output logic       y0,
    output logic       y1,
    output logic       y2,
    output logic       y3,
    output logic       y4,
    output logic       y5,
    output logic       y6,
    output logic       y7,
    output logic       y8,
    output logic       y9,
    output logic       y10,
    output logic       y11,
    output logic       y12,
    output logic       y13,
    output logic       y14,
    output logic       y15,
    output logic       valid
);

    localparam int unsigned NUM_LINES = 16;
    localparam logic [NUM_LINES-1:0] INACTIVE = {NUM_LINES{ACTIVE_LOW}};

    logic [NUM_LINES-1:0] y_q;
    logic [NUM_LINES-1:0] y_d_c;

    // Next decode: flip the selected line away from the inactive level.
    always_comb begin
        y_d_c = INACTIVE;
        if (en) begin
            y_d_c = INACTIVE ^ (NUM_LINES'(1) << sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= INACTIVE;
            valid <= 1'b0;
        end else begin
            y_q   <= y_d_c;
            valid <= en;
        end
    end

    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];
    assign y4  = y_q[4];
    assign y5  = y_q[5];
    assign y6  = y_q[6];
    assign y7  = y_q[7];
    assign y8  = y_q[8];
    assign y9  = y_q[9];
    assign y10 = y_q[10];
    assign y11 = y_q[11];
    assign y12 = y_q[12];
    assign y13 = y_q[13];
    assign y14 = y_q[14];
    assign y15 = y_q[15];

endmodule

// File: tb/tb_decoder_4_to_16.sv
// Bench for decoder_4_to_16: active-high and active-low builds share stimulus and
// are both compared against a line-by-line reference model.
module tb_decoder_4_to_16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [15:0] yh;
    logic [15:0] yl;
    logic        vh;
    logic        vl;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: what the outputs should currently represent.
    bit       m_valid = 1'b0;
    int       m_sel = 0;

    always #5 clk = ~clk;

    decoder_4_to_16 #(.ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .y0(yh[0]), .y1(yh[1]), .y2(yh[2]), .y3(yh[3]),
        .y4(yh[4]), .y5(yh[5]), .y6(yh[6]), .y7(yh[7]),
        .y8(yh[8]), .y9(yh[9]), .y10(yh[10]), .y11(yh[11]),
        .y12(yh[12]), .y13(yh[13]), .y14(yh[14]), .y15(yh[15]),
        .valid(vh)
    );

    decoder_4_to_16 #(.ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .y0(yl[0]), .y1(yl[1]), .y2(yl[2]), .y3(yl[3]),
        .y4(yl[4]), .y5(yl[5]), .y6(yl[6]), .y7(yl[7]),
        .y8(yl[8]), .y9(yl[9]), .y10(yl[10]), .y11(yl[11]),
        .y12(yl[12]), .y13(yl[13]), .y14(yl[14]), .y15(yl[15]),
        .valid(vl)
    );

    // Expected {valid, y15..y0}: a line is active only if it is the decoded index.
    function automatic logic [16:0] expect_vec(input bit al);
        logic [16:0] v;
        v[16] = m_valid;
        for (int n = 0; n < 16; n++) begin
            v[n] = (m_valid && (n == m_sel)) ? ~al : al;
        end
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %05h want %05h", tag, $time, got, want);
        end
    endtask

    task automatic check_both(input string tag);
        check_eq({tag, "/hi"}, {vh, yh}, expect_vec(1'b0));
        check_eq({tag, "/lo"}, {vl, yl}, expect_vec(1'b1));
    endtask

    // Advance one rising edge, update the model from sampled inputs, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
        end else begin
            m_valid = en;
            m_sel   = int'(sel);
        end
        #1;
        check_both(tag);
    endtask

    task automatic drive(input logic e, input logic [3:0] s);
        @(negedge clk);
        en  = e;
        sel = s;
    endtask

    task automatic rst_on;
        rst     = 1'b1;
        m_valid = 1'b0;
    endtask

    initial begin
        // Come out of an idle edge, then decode y9 so the reset effect is visible.
        drive(1'b0, 4'd0);
        step("idle");
        drive(1'b1, 4'd9);
        step("pre_rst_y9");

        // Asynchronous reset with sel=5, en=1: inactive immediately, no edge needed.
        drive(1'b1, 4'd5);
        #1 rst_on();
        #1 check_both("rst_immediate");
        step("rst_held_edge1");
        step("rst_held_edge2");
        @(negedge clk);
        rst = 1'b0;
        step("rst_release_y5");

        // Exhaustive sweep, one code per clock.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i));
            step($sformatf("sweep_%0d", i));
        end

        // Enable gating.
        drive(1'b1, 4'd10);
        step("gate_y10");
        drive(1'b0, 4'd10);
        step("gate_off");

        // Mid-cycle sel change must not show until the next edge.
        drive(1'b1, 4'd3);
        step("lat_y3");
        #2 sel = 4'd12;
        #1 check_both("lat_hold_y3");
        step("lat_y12");

        // Short reset pulse while y7 is active.
        drive(1'b1, 4'd7);
        step("mid_y7");
        @(negedge clk);
        #1 rst_on();
        #1 check_both("mid_rst_drop");
        #1 rst = 1'b0;
        #1 check_both("mid_rst_released_no_edge");
        step("mid_resume_y7");

        // Randomized traffic with occasional async reset pulses.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) begin
                #1 rst_on();
                #1 check_both("rnd_rst");
                #1 rst = 1'b0;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_4_to_16.md
# decoder_4_to_16

Registered 4-to-16 one-hot decoder: a 4-bit select code is sampled on the clock edge and drives exactly one of sixteen discrete outputs active. It sits between control/address logic and per-line enables such as chip selects, row strobes or mux enables. All outputs come from flops: the select is sampled at one clock edge and the matching output changes on that same edge, so a new code appears at the outputs by the next cycle boundary, glitch-free.

## Interface
- ACTIVE_LOW, default 0: 0 = selected output is 1 and others 0; 1 = selected output is 0 and others 1.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  decode enable, sampled on clk.
- sel  input  4  select code; sel = n selects output yn.
- y0 … y15  output  1 each  decoded outputs, one port per line, registered.
- valid  output  1  registered; 1 when the outputs hold a decoded code, 0 when all outputs are inactive.

## Operation
- The inactive level is 0, or 1 when ACTIVE_LOW = 1. The active level is the inverse.
- On each rising clk edge with rst low:
  - If en = 1: output y[sel] takes the active level and all other fifteen outputs take the inactive level; valid = 1.
  - If en = 0: all sixteen outputs take the inactive level; valid = 0.
- Every sel value 0000–1111 is legal and has a decode. There is no illegal or out-of-range code.
- In steady state with en = 1, exactly one output is active (one-hot, or one-cold when ACTIVE_LOW = 1).
- With en = 0, or during and after reset until the first enabled edge, no output is active.
- X or Z on sel or en: no requirement beyond normal simulation propagation. Benches drive known values only.
- No internal state exists beyond the 16 output flops and the valid flop.

## Timing
- Reset is asynchronous:
  - While rst = 1, all of y0–y15 are at the inactive level and valid = 0, independent of clk.
  - Outputs change immediately on rst assertion and do not wait for a clock edge.
- Reset deassertion: the first rising clk edge with rst = 0 decodes the current sel and en.
- Reset asserted mid-operation aborts the current decode. Outputs go inactive at once and valid drops.
- Latency: sel and en are sampled at edge k, and y and valid reflect them after edge k. This is one register stage with no combinational path from sel or en to the outputs.
- A sel change between edges has no effect until the next edge.
- Consecutive edges with different sel values give back-to-back decodes with no idle cycle. The old line deasserts and the new line asserts on the same edge.
- Throughput: one decode per clock.

## Test plan
- Reset: assert rst with sel = 0101 and en = 1, clocks running.
  - Required: all y = 0 and valid = 0 immediately, with no edge needed.
  - After deassert, first edge: y5 = 1, all other outputs 0, valid = 1.
- Exhaustive sweep: en = 1, drive sel = 0000 through 1111, one value per clock.
  - Required: after each edge only y[sel] = 1 and the other fifteen are 0.
  - Spot checks: 0000 gives y0, 1000 gives y8, 1111 gives y15.
- Enable gating: sel = 1010, en = 1 for one edge, then en = 0.
  - Required: y10 = 1 after the first edge.
  - After the next edge, all outputs 0 and valid = 0.
- Latency and sampling: change sel from 0011 to 1100 mid-cycle.
  - Required: y3 stays 1 until the next rising edge, then y12 = 1 and y3 = 0 on that same edge.
- Mid-operation reset: pulse rst for less than one clock period while y7 is active.
  - Required: y7 drops at once, all outputs stay 0 until the first edge after release, then decoding resumes.
- ACTIVE_LOW = 1 build, repeating the sweep.
  - Required: only y[sel] = 0 and all others 1.
  - During reset and with en = 0, all sixteen outputs = 1 and valid = 0.
